cart_load_seq: RTL and testbench
================================

Name: cart_load_seq

Overview:
- Sequences cartridge ROM loading into the 64 KB cart ROM block RAM.
- Accepts the HPS ioctl download stream and holds the console core in reset for the whole load.
- After the download, mirrors short images up to the next power-of-two size, reports the image size to the bank-switch logic, then releases the core after a fixed hold time.
- Sits between hps_io and the ROM RAM write port, and owns that port exclusively.

Parameters:
MIN_SIZE, 2048, smallest mirrored image size in bytes; power of two, at most 65536.
HOLD_CYCLES, 1024, clk_sys cycles cpu_reset stays high after load/mirror completes.

Ports:
clk_sys  in  1  system clock.
reset  in  1  synchronous, active-high.
ioctl_download  in  1  download-active level from hps_io.
ioctl_wr  in  1  one-cycle byte strobe.
ioctl_addr  in  25  byte address of ioctl_dout.
ioctl_dout  in  8  download byte.
mem_addr  out  16  ROM RAM address.
mem_din  out  8  ROM RAM write data.
mem_we  out  1  ROM RAM write enable.
mem_dout  in  8  ROM RAM read data; registered, valid one cycle after mem_addr is presented.
rom_size  out  17  byte count of the last completed image, 0..65536.
cpu_reset  out  1  hold the console core in reset.
busy  out  1  high in LOAD, MIRROR and HOLD.
size_err  out  1  sticky error flag; cleared at the start of the next download.

Behaviour:
- Reset applies in every state and aborts any operation in progress:
  - state returns to IDLE;
  - mem_we=0, mem_addr=0, mem_din=0, busy=0, size_err=0, rom_size=0;
  - cpu_reset=1, and the HOLD_CYCLES countdown is then run from IDLE, exactly as after a completed load.
- ioctl_download is edge-detected with a one-cycle delayed copy. A rising edge is seen the cycle after the level rises.
- States: IDLE, LOAD, MIRROR_RD, MIRROR_WR, HOLD.
- IDLE:
  - cpu_reset=0 once the hold from a previous load or reset has expired; busy=0.
  - A rising download edge moves to LOAD: cpu_reset=1, busy=1, size_err=0, internal count=0.
- LOAD:
  - ioctl_wr with ioctl_addr[24:16]==0 drives, in the next cycle, mem_we=1, mem_addr=ioctl_addr[15:0], mem_din=ioctl_dout (one-cycle latency, one-cycle pulse).
  - On the same write, count=max(count, ioctl_addr[15:0]+1); count is 17 bits.
  - A write with ioctl_addr[24:16]!=0 is dropped (no mem_we) and sets size_err.
- End of LOAD (falling download edge):
  - A write strobe arriving in the same cycle as the level drop is still accepted and counted.
  - rom_size is latched to count.
  - target = smallest power of two that is at least max(count, MIN_SIZE), capped at 65536.
  - count==0: set size_err, go to HOLD.
  - count==target: go to HOLD.
  - otherwise: dst=count, go to MIRROR_RD.
- MIRROR_RD: mem_we=0, mem_addr=dst-count (16-bit), then go to MIRROR_WR.
- MIRROR_WR:
  - mem_we=1, mem_addr=dst, mem_din=mem_dout.
  - dst increments; when dst reaches target go to HOLD, otherwise back to MIRROR_RD.
  - Each byte costs exactly 2 cycles; the mirror takes 2*(target-count) cycles.
  - The source may lie in already-mirrored data; this gives correct periodic replication for any count.
- HOLD:
  - cpu_reset=1, busy=1; counter loads HOLD_CYCLES-1 on entry.
  - At 0, go to IDLE; cpu_reset falls on that transition.
- A rising download edge in MIRROR_RD, MIRROR_WR or HOLD aborts the operation and re-enters LOAD, clearing count and size_err. A partially mirrored write is allowed to complete.
- ioctl_wr outside LOAD is ignored.
- mem_we never asserts outside LOAD and MIRROR_WR.
- rom_size changes only at the end of LOAD and on reset.

Test Plan:
- 4096-byte download, addresses 0..4095 -> 4096 mem_we pulses with matching addr/data, no mirror writes, rom_size=4096, cpu_reset high until HOLD_CYCLES after the falling edge.
- 2048-byte download, MIN_SIZE=4096 -> 2048 mirror writes with mem[2048+i]=mem[i], one write every 2 cycles, rom_size=2048.
- 12288-byte (FA) download -> target 16384; 4096 mirror writes with mem[12288+i]=mem[i]; rom_size=12288.
- Writes at ioctl_addr 0x10000 and 0x1FFFF interleaved with a 4K image -> no mem_we for those writes, size_err=1, rom_size=4096; a fresh download clears size_err.
- Download raised and dropped with no writes -> size_err=1, rom_size=0, no mem_we, cpu_reset released after HOLD_CYCLES.
- New rising download edge mid-MIRROR, then reset asserted mid-LOAD -> MIRROR aborts into LOAD with count=0; reset yields IDLE, mem_we=0, rom_size=0, cpu_reset high for HOLD_CYCLES then low.

Source files
------------

// File: rtl/cart_load_seq_if.sv
// rtl/cart_load_seq_if.sv - hps_io download stream and cart ROM RAM port bundle
// master drives the ioctl stream and RAM read data; slave is the load sequencer.
interface cart_load_seq_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic [16:0] rom_size;
  logic        cpu_reset;
  logic        busy;
  logic        size_err;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_dout,
    input  mem_addr, mem_din, mem_we, rom_size, cpu_reset, busy, size_err
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, mem_dout,
    output mem_addr, mem_din, mem_we, rom_size, cpu_reset, busy, size_err
  );
endinterface

// File: rtl/cart_load_seq.sv
// rtl/cart_load_seq.sv - cart ROM load, power-of-two mirror and core reset sequencer
// Owns the ROM RAM write port; the console core stays in reset until the image is settled.
module cart_load_seq #(
  parameter int MIN_SIZE    = 2048,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic           clk_sys,
  input  logic           reset,
  cart_load_seq_if.slave bus
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MIRROR_RD,
    S_MIRROR_WR,
    S_HOLD
  } state_t;

  state_t        state_q;
  logic          dl_q;
  logic [16:0]   count_q;
  logic [16:0]   dst_q;
  logic [16:0]   target_q;
  logic [HW-1:0] hold_q;
  logic          rst_hold_q;
  logic          src_ok_q;
  logic          mir_q;
  logic [15:0]   addr_q;
  logic [7:0]    din_q;
  logic          we_q;
  logic [16:0]   rom_size_q;
  logic          cpu_reset_q;
  logic          busy_q;
  logic          size_err_q;

  logic          rise;
  logic          fall;
  logic          wr_ok;
  logic          wr_bad;
  logic [16:0]   wr_end;
  logic [16:0]   count_d;
  logic [16:0]   target_d;

  function automatic logic [16:0] pow2_target(input logic [16:0] n);
    logic [17:0] t;
    t = 18'(MIN_SIZE);
    for (int i = 0; i < 17; i++) begin
      if (t < {1'b0, n}) t = t << 1;
    end
    if (t > 18'h10000) t = 18'h10000;
    return t[16:0];
  endfunction

  assign rise   = bus.ioctl_download & ~dl_q;
  assign fall   = ~bus.ioctl_download & dl_q;
  assign wr_ok  = (state_q == S_LOAD) && bus.ioctl_wr && (bus.ioctl_addr[24:16] == 9'd0);
  assign wr_bad = (state_q == S_LOAD) && bus.ioctl_wr && (bus.ioctl_addr[24:16] != 9'd0);
  assign wr_end = {1'b0, bus.ioctl_addr[15:0]} + 17'd1;

  always_comb begin
    count_d = count_q;
    if (wr_ok && (wr_end > count_q)) count_d = wr_end;
  end

  assign target_d = pow2_target(count_d);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dl_q        <= 1'b0;
      count_q     <= '0;
      dst_q       <= '0;
      target_q    <= '0;
      hold_q      <= HOLD_LOAD;
      rst_hold_q  <= 1'b1;
      src_ok_q    <= 1'b0;
      mir_q       <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
      rom_size_q  <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      size_err_q  <= 1'b0;
    end else begin
      dl_q  <= bus.ioctl_download;
      we_q  <= 1'b0;
      mir_q <= 1'b0;
      // A new download preempts everything; a write already on the port still lands.
      if (rise) begin
        state_q     <= S_LOAD;
        count_q     <= '0;
        size_err_q  <= 1'b0;
        cpu_reset_q <= 1'b1;
        busy_q      <= 1'b1;
        rst_hold_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rst_hold_q) begin
              if (hold_q == '0) begin
                rst_hold_q  <= 1'b0;
                cpu_reset_q <= 1'b0;
              end else begin
                hold_q <= hold_q - 1'b1;
              end
            end
          end
          S_LOAD: begin
            count_q <= count_d;
            if (wr_ok) begin
              we_q   <= 1'b1;
              addr_q <= bus.ioctl_addr[15:0];
              din_q  <= bus.ioctl_dout;
            end
            if (wr_bad) size_err_q <= 1'b1;
            if (fall) begin
              rom_size_q <= count_d;
              target_q   <= target_d;
              dst_q      <= count_d;
              if ((count_d == '0) || (count_d == target_d)) begin
                state_q <= S_HOLD;
                hold_q  <= HOLD_LOAD;
                if (count_d == '0) size_err_q <= 1'b1;
              end else begin
                // A trailing write owns the port this cycle, so the first read waits one.
                state_q  <= S_MIRROR_RD;
                src_ok_q <= ~wr_ok;
                if (!wr_ok) addr_q <= 16'd0;
              end
            end
          end
          S_MIRROR_RD: begin
            if (src_ok_q) begin
              state_q <= S_MIRROR_WR;
              we_q    <= 1'b1;
              mir_q   <= 1'b1;
              addr_q  <= dst_q[15:0];
            end else begin
              src_ok_q <= 1'b1;
              addr_q   <= 16'(dst_q - count_q);
            end
          end
          S_MIRROR_WR: begin
            dst_q <= dst_q + 17'd1;
            if ((dst_q + 17'd1) == target_q) begin
              state_q <= S_HOLD;
              hold_q  <= HOLD_LOAD;
            end else begin
              state_q  <= S_MIRROR_RD;
              src_ok_q <= 1'b1;
              addr_q   <= 16'(dst_q + 17'd1 - count_q);
            end
          end
          S_HOLD: begin
            if (hold_q == '0) begin
              state_q     <= S_IDLE;
              cpu_reset_q <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              hold_q <= hold_q - 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Mirror data passes straight from the registered RAM read port to the write port.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = mir_q ? bus.mem_dout : din_q;
  assign bus.mem_we    = we_q;
  assign bus.rom_size  = rom_size_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.busy      = busy_q;
  assign bus.size_err  = size_err_q;
endmodule

// File: tb/tb_cart_load_seq.sv
// tb/tb_cart_load_seq.sv - directed and randomized bench for cart_load_seq
// Models the ROM RAM and predicts image contents, mirror length and reset timing.
module tb_cart_load_seq;
  localparam int MIN_SIZE = 4096;
  localparam int HOLD     = 64;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  cart_load_seq_if bus();

  cart_load_seq #(.MIN_SIZE(MIN_SIZE), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  logic [7:0] ram [65536];
  logic [7:0] img [65536];

  always @(posedge clk_sys) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= ram[bus.mem_addr];
  end

  int          cyc = 0;
  int          load_cnt = 0;
  int          mir_cnt = 0;
  int          gap_bad = 0;
  int          last_mir = -1;
  logic [16:0] cur_count = 17'h1FFFF;

  // Writes at or above the image length can only come from mirroring.
  always @(negedge clk_sys) begin
    cyc = cyc + 1;
    if (bus.mem_we === 1'b1) begin
      if ({1'b0, bus.mem_addr} >= cur_count) begin
        mir_cnt = mir_cnt + 1;
        if (last_mir >= 0 && (cyc - last_mir) != 2) gap_bad = gap_bad + 1;
        last_mir = cyc;
      end else begin
        load_cnt = load_cnt + 1;
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_target(input int cnt);
    int t;
    int m;
    t = MIN_SIZE;
    m = (cnt > MIN_SIZE) ? cnt : MIN_SIZE;
    while (t < m) t = t * 2;
    return (t > 65536) ? 65536 : t;
  endfunction

  function automatic int mem_mism(input int cnt, input int tgt);
    int bad;
    bad = 0;
    for (int a = 0; a < tgt; a++) begin
      if (ram[a] !== img[a % cnt]) bad++;
    end
    return bad;
  endfunction

  task automatic clear_stats(input int cnt);
    load_cnt  = 0;
    mir_cnt   = 0;
    gap_bad   = 0;
    last_mir  = -1;
    cur_count = 17'(cnt);
  endtask

  task automatic start_dl();
    bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
    if ($urandom_range(0, 3) == 0) @(negedge clk_sys);
  endtask

  task automatic load_byte(input int a);
    logic [7:0] d;
    d = 8'($urandom);
    img[a] = d;
    wr(25'(a), d);
  endtask

  // Drops the download level (optionally with a last write in that same cycle) and
  // counts clock edges until cpu_reset is released.
  task automatic drop_and_time(input bit with_wr, input int a, output int n);
    logic [7:0] d;
    d = 8'($urandom);
    if (with_wr) begin
      img[a]         = d;
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(a);
      bus.ioctl_dout = d;
    end
    bus.ioctl_download = 1'b0;
    n = 0;
    do begin
      @(negedge clk_sys);
      bus.ioctl_wr = 1'b0;
      n++;
    end while (bus.cpu_reset === 1'b1 && n < 20000);
  endtask

  task automatic reset_and_time(output int n);
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (bus.cpu_reset === 1'b1 && n < 5000);
  endtask

  initial begin
    int n;
    int tgt;
    int snap;

    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_din", 32'(bus.mem_din), 32'd0);
    check("rst_rom_size", 32'(bus.rom_size), 32'd0);
    check("rst_size_err", 32'(bus.size_err), 32'd0);
    check("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    reset_and_time(n);
    check("rst_hold_len", 32'(n), 32'(HOLD));

    // 4 KB image, last byte strobed in the same cycle the level drops
    clear_stats(4096);
    start_dl();
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    for (int a = 0; a < 4095; a++) load_byte(a);
    drop_and_time(1'b1, 4095, n);
    check("t1_hold_len", 32'(n), 32'(1 + HOLD));
    check("t1_load_we", 32'(load_cnt), 32'd4096);
    check("t1_mirror_we", 32'(mir_cnt), 32'd0);
    check("t1_rom_size", 32'(bus.rom_size), 32'd4096);
    check("t1_size_err", 32'(bus.size_err), 32'd0);
    check("t1_mem", 32'(mem_mism(4096, exp_target(4096))), 32'd0);
    check("t1_busy_end", 32'(bus.busy), 32'd0);

    // 2 KB image mirrored once up to MIN_SIZE
    clear_stats(2048);
    start_dl();
    for (int a = 0; a < 2048; a++) load_byte(a);
    tgt = exp_target(2048);
    drop_and_time(1'b0, 0, n);
    check("t2_hold_len", 32'(n), 32'(1 + 2 * (tgt - 2048) + HOLD));
    check("t2_load_we", 32'(load_cnt), 32'd2048);
    check("t2_mirror_we", 32'(mir_cnt), 32'(tgt - 2048));
    check("t2_mirror_gap", 32'(gap_bad), 32'd0);
    check("t2_rom_size", 32'(bus.rom_size), 32'd2048);
    check("t2_mem", 32'(mem_mism(2048, tgt)), 32'd0);

    // 12 KB image written top-down, padded to 16 KB
    clear_stats(12288);
    start_dl();
    for (int a = 12287; a >= 0; a--) load_byte(a);
    tgt = exp_target(12288);
    drop_and_time(1'b0, 0, n);
    check("t3_target", 32'(tgt), 32'd16384);
    check("t3_hold_len", 32'(n), 32'(1 + 2 * (tgt - 12288) + HOLD));
    check("t3_mirror_we", 32'(mir_cnt), 32'(tgt - 12288));
    check("t3_mirror_gap", 32'(gap_bad), 32'd0);
    check("t3_rom_size", 32'(bus.rom_size), 32'd12288);
    check("t3_mem", 32'(mem_mism(12288, tgt)), 32'd0);

    // 4 KB image with two out-of-range writes mixed in
    clear_stats(4096);
    start_dl();
    for (int a = 0; a < 4096; a++) begin
      if (a == 1000) wr(25'h10000, 8'hA5);
      if (a == 3000) wr(25'h1FFFF, 8'h5A);
      load_byte(a);
    end
    drop_and_time(1'b0, 0, n);
    check("t4_load_we", 32'(load_cnt), 32'd4096);
    check("t4_size_err", 32'(bus.size_err), 32'd1);
    check("t4_rom_size", 32'(bus.rom_size), 32'd4096);
    check("t4_mem", 32'(mem_mism(4096, 4096)), 32'd0);

    // Fresh download clears the error, then ends with no bytes at all
    clear_stats(0);
    start_dl();
    check("t5_err_cleared", 32'(bus.size_err), 32'd0);
    drop_and_time(1'b0, 0, n);
    check("t5_hold_len", 32'(n), 32'(1 + HOLD));
    check("t5_size_err", 32'(bus.size_err), 32'd1);
    check("t5_rom_size", 32'(bus.rom_size), 32'd0);
    check("t5_any_we", 32'(load_cnt + mir_cnt), 32'd0);

    // Abort a mirror with a new download, then reload a 256-byte image
    clear_stats(2048);
    start_dl();
    for (int a = 0; a < 2048; a++) load_byte(a);
    bus.ioctl_download = 1'b0;
    repeat (300) @(negedge clk_sys);
    check("t6_mirror_busy", 32'(bus.busy), 32'd1);
    bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    snap = mir_cnt;
    repeat (10) @(negedge clk_sys);
    check("t6_mirror_stopped", 32'(mir_cnt), 32'(snap));
    check("t6_reload_busy", 32'(bus.busy), 32'd1);
    check("t6_reload_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    clear_stats(256);
    for (int a = 0; a < 256; a++) load_byte(a);
    tgt = exp_target(256);
    drop_and_time(1'b0, 0, n);
    check("t6_hold_len", 32'(n), 32'(1 + 2 * (tgt - 256) + HOLD));
    check("t6_rom_size", 32'(bus.rom_size), 32'd256);
    check("t6_mem", 32'(mem_mism(256, tgt)), 32'd0);

    // Reset in the middle of a load
    start_dl();
    for (int a = 0; a < 50; a++) load_byte(a);
    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("t7_busy", 32'(bus.busy), 32'd0);
    check("t7_we", 32'(bus.mem_we), 32'd0);
    check("t7_rom_size", 32'(bus.rom_size), 32'd0);
    check("t7_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    reset_and_time(n);
    check("t7_hold_len", 32'(n), 32'(HOLD));
    check("t7_idle_busy", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
